// File: rtl/data_types_pkg.sv
// Shared types for the UART transmit path.
//   config_t     : software configuration word handed to uart_tx
//   arb_state_t  : uart_tx_arbiter FSM state
//   UART_FRAME_W : width of one frame payload (8 data bits + optional 9th)
package data_types_pkg;

    localparam int UART_FRAME_W = 9;

    typedef struct packed {
        logic [15:0] br_div;   // baud-rate divider
        logic        word;     // 0: 8-bit frame, 1: 9-bit frame
        logic        stop;     // 0: one stop bit, 1: two stop bits
        logic        en;       // transmitter enabled
    } config_t;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_START = 2'd1,
        ARB_RUN   = 2'd2
    } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority selector.
// Scans req_valid upward starting at rr_ptr (inclusive), wrapping modulo
// N_REQ, and returns the first set requester.
//   req_valid [N_REQ]         in  : requests
//   rr_ptr    [$clog2(N_REQ)] in  : highest-priority index this cycle
//   gnt       [N_REQ]         out : one-hot winner (all-zero if no request)
//   gnt_idx   [$clog2(N_REQ)] out : index of the winner (0 if none)
//   gnt_vld                   out : at least one request present
module rr_pick #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [$clog2(N_REQ)-1:0] rr_ptr,
    output logic [N_REQ-1:0]         gnt,
    output logic [$clog2(N_REQ)-1:0] gnt_idx,
    output logic                     gnt_vld
);
    localparam int IW = $clog2(N_REQ);

    int            slot;
    logic [IW-1:0] slot_idx;
    logic          found;

    always_comb begin
        gnt      = '0;
        gnt_idx  = '0;
        found    = 1'b0;
        slot     = 0;
        slot_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            // Wrap by subtraction so non-power-of-two N_REQ works too.
            slot = int'(rr_ptr) + i;
            if (slot >= N_REQ) slot = slot - N_REQ;
            slot_idx = IW'(slot);
            if (!found && req_valid[slot_idx]) begin
                found         = 1'b1;
                gnt[slot_idx] = 1'b1;
                gnt_idx       = slot_idx;
            end
        end
    end

    assign gnt_vld = |req_valid;

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin scheduler sharing one uart_tx among N_REQ
// frame producers. One frame is in flight at a time; the next grant waits
// for the transmitter to report idle again.
//
// Build option: UART_TX_ARB_CFG_SHADOW_EN
//   defined   : tx_cfg is a register reloaded only while IDLE and tx_idle=1,
//               so configuration can never change under a running frame.
//   undefined : tx_cfg follows cfg_in directly.
//
// Ports:
//   clk, rst        in  : clock, synchronous active-high reset
//   req_valid/data  in  : per-requester offer and 9-bit payload
//   req_ready       out : one-hot accept, only ever set in IDLE
//   cfg_in          in  : software configuration
//   tx_cfg          out : configuration presented to uart_tx
//   tx_data         out : frame to uart_tx (held after the frame ends)
//   tx_enable       out : start request to uart_tx
//   tx_idle         in  : uart_tx idle flag
//   busy            out : FSM not in IDLE
//   grant_id        out : last granted requester
//   err_timeout     out : one-cycle pulse when tx_idle never fell after a start
module uart_tx_arbiter
    import data_types_pkg::*;
#(
    parameter int N_REQ         = 4,
    parameter int START_TIMEOUT = 64
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [N_REQ-1:0]                       req_valid,
    input  logic [N_REQ-1:0][UART_FRAME_W-1:0]     req_data,
    output logic [N_REQ-1:0]                       req_ready,
    input  config_t                                cfg_in,
    output config_t                                tx_cfg,
    output logic [UART_FRAME_W-1:0]                tx_data,
    output logic                                   tx_enable,
    input  logic                                   tx_idle,
    output logic                                   busy,
    output logic [$clog2(N_REQ)-1:0]               grant_id,
    output logic                                   err_timeout
);
    localparam int IW = $clog2(N_REQ);
    localparam int TW = $clog2(START_TIMEOUT) + 1;

    arb_state_t              state, state_n;
    logic [IW-1:0]           rr_ptr, rr_ptr_n;
    logic [IW-1:0]           grant_id_n;
    logic [TW-1:0]           timer, timer_n;
    logic [UART_FRAME_W-1:0] tx_data_n;
    logic                    tx_enable_n;
    logic                    err_n;
    logic                    eff_en;

    logic [N_REQ-1:0]        pick_gnt;
    logic [IW-1:0]           pick_idx;
    logic                    pick_vld;

    // Next pointer after the requester just served (granted or timed out).
    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] id);
        if (id == IW'(N_REQ - 1)) return '0;
        return id + 1'b1;
    endfunction

`ifdef UART_TX_ARB_CFG_SHADOW_EN
    config_t cfg_q;

    // Reload only between frames; reset leaves en=0, so the first grant
    // waits one cycle for the first load.
    always_ff @(posedge clk) begin
        if (rst)
            cfg_q <= '0;
        else if (state == ARB_IDLE && tx_idle)
            cfg_q <= cfg_in;
    end

    assign tx_cfg = cfg_q;
    assign eff_en = cfg_q.en;
`else
    assign tx_cfg = cfg_in;
    assign eff_en = cfg_in.en;
`endif

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr),
        .gnt       (pick_gnt),
        .gnt_idx   (pick_idx),
        .gnt_vld   (pick_vld)
    );

    always_comb begin
        state_n     = state;
        rr_ptr_n    = rr_ptr;
        grant_id_n  = grant_id;
        timer_n     = timer;
        tx_data_n   = tx_data;
        tx_enable_n = tx_enable;
        err_n       = 1'b0;
        req_ready   = '0;

        unique case (state)
            ARB_IDLE: begin
                // tx_idle is part of the grant so a start can never land on
                // a transmitter that is still shifting a previous frame.
                if (tx_idle && eff_en && pick_vld) begin
                    req_ready   = pick_gnt;
                    tx_data_n   = req_data[pick_idx];
                    grant_id_n  = pick_idx;
                    tx_enable_n = 1'b1;
                    timer_n     = '0;
                    state_n     = ARB_START;
                end
            end
            ARB_START: begin
                if (!tx_idle) begin
                    tx_enable_n = 1'b0;
                    state_n     = ARB_RUN;
                end else if (timer == TW'(START_TIMEOUT - 1)) begin
                    // Transmitter never picked up the frame: drop it and
                    // move on so one stuck start cannot starve the others.
                    err_n       = 1'b1;
                    tx_enable_n = 1'b0;
                    rr_ptr_n    = wrap_inc(grant_id);
                    state_n     = ARB_IDLE;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            ARB_RUN: begin
                if (tx_idle) begin
                    rr_ptr_n = wrap_inc(grant_id);
                    state_n  = ARB_IDLE;
                end
            end
            default: begin
                tx_enable_n = 1'b0;
                state_n     = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ARB_IDLE;
            rr_ptr      <= '0;
            grant_id    <= '0;
            timer       <= '0;
            tx_data     <= '0;
            tx_enable   <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state       <= state_n;
            rr_ptr      <= rr_ptr_n;
            grant_id    <= grant_id_n;
            timer       <= timer_n;
            tx_data     <= tx_data_n;
            tx_enable   <= tx_enable_n;
            err_timeout <= err_n;
        end
    end

    assign busy = (state != ARB_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with a behavioural uart_tx stand-in.
module tb_uart_tx_arbiter;
    import data_types_pkg::*;

    localparam int N  = 4;
    localparam int TO = 64;

    logic                clk = 1'b0;
    logic                rst;
    logic [N-1:0]        req_valid;
    logic [N-1:0][8:0]   req_data;
    logic [N-1:0]        req_ready;
    config_t             cfg_in, tx_cfg;
    logic [8:0]          tx_data;
    logic                tx_enable, tx_idle, busy, err_timeout;
    logic [1:0]          grant_id;

    uart_tx_arbiter #(.N_REQ(N), .START_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .cfg_in(cfg_in), .tx_cfg(tx_cfg),
        .tx_data(tx_data), .tx_enable(tx_enable), .tx_idle(tx_idle),
        .busy(busy), .grant_id(grant_id), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    // Transmitter stand-in: takes a frame when enabled while idle, then stays
    // busy for a frame-length determined by the configuration. 'stuck' makes
    // it ignore starts, to exercise the start timeout.
    logic       stuck = 1'b0;
    logic       ovl   = 1'b0;
    int         scnt;
    logic [8:0] cap_q[$];

    always @(posedge clk) begin
        if (rst) begin
            tx_idle <= 1'b1;
            scnt    <= 0;
        end else if (!tx_idle) begin
            if (scnt <= 1) tx_idle <= 1'b1;
            scnt <= scnt - 1;
            if (|req_ready) ovl <= 1'b1;
        end else if (tx_enable && !stuck) begin
            cap_q.push_back(tx_cfg.word ? tx_data : {1'b0, tx_data[7:0]});
            tx_idle <= 1'b0;
            scnt    <= (10 + int'(tx_cfg.word) + int'(tx_cfg.stop)) * int'(tx_cfg.br_div);
        end
    end

    int         n_tests = 0;
    int         n_fail  = 0;
    int         rd      = 0;
    int         rdy_bad = 0;
    logic [8:0] exp_q[$];
    int         ord_q[$];

    typedef struct packed {
        logic            do_rst;
        logic [3:0]      mask;
        logic [3:0][8:0] d;
        logic [2:0]      n;
        logic [3:0][1:0] ord;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: record acceptances at the negedge, retire accepted offers
    // just after the posedge.
    task automatic step();
        logic [N-1:0] acc;
        @(negedge clk);
        acc = req_valid & req_ready;
        if ($countones(req_ready) > 1 || (req_ready & ~req_valid) != '0) rdy_bad++;
        for (int i = 0; i < N; i++) if (acc[i]) ord_q.push_back(i);
        @(posedge clk);
        #1;
        req_valid = req_valid & ~acc;
    endtask

    task automatic run_quiet(input string name);
        int k;
        k = 0;
        while ((req_valid != '0 || busy || !tx_idle) && k < 3000) begin
            step();
            k++;
        end
        if (k >= 3000) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: no completion within 3000 cycles", name);
        end
    endtask

    task automatic check_frames(input string name);
        while (rd < cap_q.size()) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL %s: unexpected frame %0h", name, cap_q[rd]);
            end else begin
                chk(name, 32'(cap_q[rd]), 32'(exp_q.pop_front()));
            end
            rd++;
        end
        chk({name, "_pending"}, exp_q.size(), 0);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
`ifdef UART_TX_ARB_CFG_SHADOW_EN
        step();
`endif
    endtask

    initial begin
        int t_en, t_err;

        tbl[0] = '{1'b1, 4'b1111, {9'h44, 9'h33, 9'h22, 9'h11}, 3'd4, {2'd3, 2'd2, 2'd1, 2'd0}};
        tbl[1] = '{1'b0, 4'b1001, {9'h05a, 9'h0, 9'h0, 9'h0a5}, 3'd2, {2'd0, 2'd0, 2'd3, 2'd0}};
        tbl[2] = '{1'b0, 4'b0110, {9'h0, 9'h77, 9'h66, 9'h0}, 3'd2, {2'd0, 2'd0, 2'd2, 2'd1}};
        tbl[3] = '{1'b0, 4'b0011, {9'h0, 9'h0, 9'h80, 9'h01}, 3'd2, {2'd0, 2'd0, 2'd1, 2'd0}};
        tbl[4] = '{1'b0, 4'b1010, {9'h0c3, 9'h0, 9'h3c, 9'h0}, 3'd2, {2'd0, 2'd0, 2'd1, 2'd3}};

        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        cfg_in    = '{br_div: 16'd8, word: 1'b0, stop: 1'b0, en: 1'b1};
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx_enable", 32'(tx_enable), 0);
        chk("rst_tx_data", 32'(tx_data), 0);
        chk("rst_grant_id", 32'(grant_id), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(err_timeout), 0);
        chk("rst_ready", 32'(req_ready), 0);
        rst = 1'b0;
`ifdef UART_TX_ARB_CFG_SHADOW_EN
        step();
`else
        chk("cfg_passthru", 32'(tx_cfg), 32'(cfg_in));
`endif

        // Single request on requester 2.
        req_data[2] = 9'h08e;
        req_valid   = 4'b0100;
        exp_q.push_back(9'h08e);
        #1;
        chk("single_ready", 32'(req_ready), 32'(4'b0100));
        step();
        chk("single_tx_enable", 32'(tx_enable), 1);
        chk("single_grant_id", 32'(grant_id), 2);
        chk("single_tx_data", 32'(tx_data), 32'(9'h08e));
        chk("single_busy", 32'(busy), 1);
        chk("single_ready_off", 32'(req_ready), 0);
        for (int k = 0; k < 200 && tx_idle; k++) step();
        for (int k = 0; k < 200 && !tx_idle; k++) step();
        chk("single_busy_at_idle", 32'(busy), 1);
        step();
        chk("single_busy_fall", 32'(busy), 0);
        check_frames("single_frame");

        // Round-robin table.
        for (int v = 0; v < 5; v++) begin
            if (tbl[v].do_rst) do_reset();
            ord_q.delete();
            req_data = tbl[v].d;
            for (int k = 0; k < int'(tbl[v].n); k++) exp_q.push_back(tbl[v].d[tbl[v].ord[k]]);
            req_valid = tbl[v].mask;
            run_quiet($sformatf("vec%0d", v));
            chk($sformatf("vec%0d_count", v), ord_q.size(), 32'(tbl[v].n));
            for (int k = 0; k < int'(tbl[v].n) && k < ord_q.size(); k++)
                chk($sformatf("vec%0d_order%0d", v, k), ord_q[k], 32'(tbl[v].ord[k]));
            check_frames($sformatf("vec%0d_frames", v));
        end

        // 9-bit frame.
        cfg_in.word = 1'b1;
        req_data[1] = 9'h1fe;
        req_valid   = 4'b0010;
        exp_q.push_back(9'h1fe);
        run_quiet("word9");
        check_frames("word9_frame");
        chk("word9_tx_data_held", 32'(tx_data), 32'(9'h1fe));
        cfg_in.word = 1'b0;

        // Start timeout on requester 0, then requester 1 served.
        stuck = 1'b1;
        ord_q.delete();
        req_data[0] = 9'h055;
        req_data[1] = 9'h066;
        req_valid   = 4'b0011;
        exp_q.push_back(9'h066);
        t_en  = -1;
        t_err = -1;
        for (int k = 1; k < 300; k++) begin
            step();
            if (tx_enable && t_en < 0) t_en = k;
            if (err_timeout) begin
                t_err = k;
                break;
            end
        end
        stuck = 1'b0;
        chk("timeout_delay", 32'(t_err - t_en), TO);
        chk("timeout_grant_id", 32'(grant_id), 0);
        chk("timeout_busy", 32'(busy), 0);
        step();
        chk("timeout_pulse_len", 32'(err_timeout), 0);
        run_quiet("after_timeout");
        chk("timeout_count", ord_q.size(), 2);
        if (ord_q.size() == 2) chk("timeout_next", ord_q[1], 1);
        check_frames("timeout_frames");

        // en=0 blocks grants.
        cfg_in.en = 1'b0;
        step();
        step();
        ord_q.delete();
        req_data[3] = 9'h099;
        req_valid   = 4'b1000;
        repeat (20) step();
        chk("en0_no_grant", ord_q.size(), 0);
        chk("en0_busy", 32'(busy), 0);
        cfg_in.en = 1'b1;
        exp_q.push_back(9'h099);
        run_quiet("en1");
        check_frames("en1_frame");

`ifdef UART_TX_ARB_CFG_SHADOW_EN
        // Configuration held while a frame is running.
        req_data[0] = 9'h012;
        req_valid   = 4'b0001;
        exp_q.push_back(9'h012);
        for (int k = 0; k < 200 && tx_idle; k++) step();
        cfg_in.stop = 1'b1;
        step();
        chk("shadow_hold", 32'(tx_cfg.stop), 0);
        run_quiet("shadow");
        step();
        chk("shadow_update", 32'(tx_cfg.stop), 1);
        cfg_in.stop = 1'b0;
        step();
        check_frames("shadow_frame");
`endif

        // Reset during RUN clears the pointer.
        req_data[1] = 9'h021;
        req_valid   = 4'b0010;
        exp_q.push_back(9'h021);
        run_quiet("pre_rst");
        req_data[3] = 9'h042;
        req_valid   = 4'b1000;
        exp_q.push_back(9'h042);
        for (int k = 0; k < 200 && tx_idle; k++) step();
        step();
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_tx_enable", 32'(tx_enable), 0);
        chk("midrst_busy", 32'(busy), 0);
        rst = 1'b0;
`ifdef UART_TX_ARB_CFG_SHADOW_EN
        step();
`endif
        ord_q.delete();
        req_data[0] = 9'h0f0;
        req_data[2] = 9'h00f;
        req_valid   = 4'b0101;
        exp_q.push_back(9'h0f0);
        exp_q.push_back(9'h00f);
        run_quiet("post_rst");
        chk("post_rst_count", ord_q.size(), 2);
        if (ord_q.size() == 2) chk("post_rst_first", ord_q[0], 0);
        check_frames("post_rst_frames");

        chk("ready_onehot", rdy_bad, 0);
        chk("no_overlap", 32'(ovl), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
